otter_mem_arbiter: RTL and testbench
====================================

# otter_mem_arbiter

Single-port memory arbiter for the pipelined OTTER. It shares one synchronous, single-ported memory between the instruction-fetch stage and the memory stage's load/store port. It grants one access per cycle and routes the one-cycle-latency read data back to the correct requester. It bounds fetch starvation with a data-burst counter, and holds each requester's last read word stable between returns.

## Interface
- `MAX_DATA_BURST`, default 3: consecutive cycles fetch may lose to data before fetch is forced through; legal range 1–15.
- `CLK` in 1: system clock, rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `if_req` in 1: fetch read request.
- `if_addr` in 32: fetch byte address, word-aligned.
- `if_gnt` out 1: fetch accepted this cycle. The pipeline stalls PC and IF/DE while `if_req && !if_gnt`.
- `if_rvalid` out 1: fetch read data valid.
- `if_rdata` out 32: fetch read data, held.
- `d_req` in 1: data access request.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data.
- `d_size` in 2: 0 = byte, 1 = half, 2 = word.
- `d_sign` in 1: 1 = unsigned load.
- `d_gnt` out 1: data access accepted this cycle.
- `d_rvalid` out 1: load data valid.
- `d_rdata` out 32: load data, held.
- `m_en` out 1: memory access enable.
- `m_we` out 1: memory write enable.
- `m_addr` out 32: memory address.
- `m_wdata` out 32: memory write data.
- `m_size` out 2: memory access size.
- `m_sign` out 1: memory sign control.
- `m_rdata` in 32: memory read data, valid the cycle after a read with `m_en=1`, `m_we=0`.

## Operation
- **Grant** (combinational, same cycle as request):
  - Only one requester active: that requester wins.
  - Both active: data wins, unless `starve_cnt == MAX_DATA_BURST`; then fetch wins.
  - Neither active: no grant, `m_en=0`.
- **Memory drive:**
  - Winner's address, size and sign go to `m_*`.
  - Fetch drives `m_we=0`, `m_size=2`, `m_sign=0`, `m_wdata=0`.
  - `m_we` is asserted only on a data store grant.
- **`starve_cnt`** (4-bit):
  - Increments, saturating at `MAX_DATA_BURST`, on each cycle data is granted while `if_req=1`.
  - Clears on any fetch grant, or on any cycle with `if_req=0`.
- **Return FSM**, `pend` state, updated every edge:
  - `PEND_NONE` → next state from this cycle's grant:
    - fetch grant → `PEND_IF`
    - data load grant → `PEND_D`
    - store or no grant → `PEND_NONE`
  - `PEND_IF` and `PEND_D` transition by the same rule. Back-to-back reads are fully pipelined.
- **Return path:**
  - `if_rvalid = (pend == PEND_IF)`; `d_rvalid = (pend == PEND_D)`.
  - `if_rdata = if_rvalid ? m_rdata : if_hold`. `if_hold` loads `m_rdata` on each edge where `if_rvalid=1`.
  - `d_rdata` and `d_hold` behave the same way.
- **Boundary cases:**
  - A store produces no `rvalid`.
  - A request dropped after grant still receives its `rvalid`. The arbiter does not cancel.
  - `d_req` and `if_req` are sampled only in the current cycle. No queueing; a losing requester must hold its request.
- **Reset** (asynchronous, any time, including with a read outstanding):
  - `pend = PEND_NONE`, `starve_cnt = 0`, `if_hold = d_hold = 0`.
  - The outstanding read's data is discarded.
  - While `RESET=1`: all grants, `m_en`, `m_we` and both `rvalid` are 0.

## Timing
- Grant-to-memory latency: 0 cycles (combinational).
- Grant-to-`rvalid` latency: exactly 1 cycle for reads.
- Throughput: one access per cycle.
- Reset values:
  - All outputs 0, except `m_size`, `m_sign` and `m_addr`, which follow the idle selection (0).
  - `rdata` outputs 0 until the first return.
- `rdata` is stable from one `rvalid` to the next.
- Combinational path: `*_req` → `*_gnt` / `m_*`. The only registered state is `pend`, `starve_cnt` and the two hold registers.

## Structure
- **Shared package `otter_mem_pkg`:**
  - `pend_t` enum: `PEND_NONE`, `PEND_IF`, `PEND_D`.
  - Size constants: `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
- **Sub-module `mem_rd_return`:** instantiated twice. Inputs: `rvalid` select and `m_rdata`. It contains the hold register and provides the held/bypass output.
- Target size: ~150–250 lines RTL.

## Test plan
- **Fetch only:** `if_req=1` with addresses 0x0, 0x4, 0x8, `d_req=0` → `if_gnt=1` each cycle; `if_rvalid` on the next three cycles with `mem[0]`, `mem[1]`, `mem[2]`; `d_rvalid` never asserted.
- **Contention:** both requests held high, `MAX_DATA_BURST=3` → grant sequence D,D,D,IF,D,D,D,IF; `starve_cnt` reads 0,1,2,3,0,1,2,3.
- **Store then load:** store 0xDEADBEEF to 0x100 with `d_size=2` → `m_we=1` that cycle and no `d_rvalid` next cycle; load from 0x100 → `d_rvalid=1` one cycle later with `d_rdata=0xDEADBEEF`.
- **Hold:** fetch read returns 0x00000013 at cycle T, then `if_req=0` → `if_rdata` stays 0x00000013 through T+5 while `m_rdata` changes.
- **Reset mid-read:** fetch granted at T, `RESET` pulsed between edges → `if_rvalid=0` at T+1, hold registers 0, `starve_cnt=0`; the first grant after release behaves as in the fetch-only case.
- **Interleave:** D load, IF, D load on consecutive cycles → `d_rvalid`, `if_rvalid`, `d_rvalid` on the following cycles, each carrying its own address's data.

Source files
------------

// File: rtl/otter_mem_pkg.sv
// Shared types for the OTTER single-port memory arbiter:
// the read-return tracking state and the memory access size encodings.
package otter_mem_pkg;

   typedef enum logic [1:0] {
      PEND_NONE = 2'd0,
      PEND_IF   = 2'd1,
      PEND_D    = 2'd2
   } pend_t;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/otter_mem_arbiter_if.sv
// Bus bundle between the OTTER fetch/data ports, the arbiter and the memory.
// slave = arbiter view, master = pipeline + memory view.
interface otter_mem_arbiter_if;

   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;

   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [1:0]  d_size;
   logic        d_sign;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;

   logic        m_en;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [1:0]  m_size;
   logic        m_sign;
   logic [31:0] m_rdata;

   modport slave (
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata,
      input  d_req, d_we, d_addr, d_wdata, d_size, d_sign,
      output d_gnt, d_rvalid, d_rdata,
      output m_en, m_we, m_addr, m_wdata, m_size, m_sign,
      input  m_rdata
   );

   modport master (
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata,
      output d_req, d_we, d_addr, d_wdata, d_size, d_sign,
      input  d_gnt, d_rvalid, d_rdata,
      input  m_en, m_we, m_addr, m_wdata, m_size, m_sign,
      output m_rdata
   );

endinterface

// File: rtl/otter_mem_arbiter_rd_return.sv
// Per-requester read return: bypasses memory data on the return cycle and
// holds the last returned word until the next return.
module mem_rd_return (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        rvalid,
   input  logic [31:0] m_rdata,
   output logic [31:0] rdata
);

   logic [31:0] hold;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)       hold <= '0;
      else if (rvalid) hold <= m_rdata;
   end

   assign rdata = rvalid ? m_rdata : hold;

endmodule

// File: rtl/otter_mem_arbiter.sv
// Single-port memory arbiter for the pipelined OTTER: data beats fetch except
// after MAX_DATA_BURST consecutive fetch losses; read data returns one cycle later.
module otter_mem_arbiter
   import otter_mem_pkg::*;
#(
   parameter int MAX_DATA_BURST = 3
) (
   input  logic CLK,
   input  logic RESET,
   otter_mem_arbiter_if.slave bus
);

   localparam logic [3:0] MAX_B = 4'(MAX_DATA_BURST);

   logic        if_win, d_win;
   logic [3:0]  starve_cnt;
   pend_t       pend, pend_nxt;
   logic [1:0]        rvld;
   logic [1:0][31:0]  rdat;

   // Grants are forced low while reset is held, even with requests present.
   always_comb begin
      if_win = 1'b0;
      d_win  = 1'b0;
      if (!RESET) begin
         if_win = bus.if_req && (!bus.d_req || starve_cnt == MAX_B);
         d_win  = bus.d_req && !if_win;
      end
   end

   assign bus.if_gnt = if_win;
   assign bus.d_gnt  = d_win;

   always_comb begin
      bus.m_en    = if_win | d_win;
      bus.m_we    = d_win & bus.d_we;
      bus.m_addr  = '0;
      bus.m_wdata = '0;
      bus.m_size  = '0;
      bus.m_sign  = 1'b0;
      if (d_win) begin
         bus.m_addr  = bus.d_addr;
         bus.m_wdata = bus.d_wdata;
         bus.m_size  = bus.d_size;
         bus.m_sign  = bus.d_sign;
      end else if (if_win) begin
         bus.m_addr  = bus.if_addr;
         bus.m_size  = SZ_WORD;
      end
   end

   // Counts consecutive cycles fetch waited behind data.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         starve_cnt <= '0;
      else if (if_win || !bus.if_req)
         starve_cnt <= '0;
      else if (d_win && starve_cnt != MAX_B)
         starve_cnt <= starve_cnt + 4'd1;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) pend <= PEND_NONE;
      else       pend <= pend_nxt;
   end

   // Every state follows the same rule, so back-to-back reads pipeline.
   always_comb begin
      pend_nxt = PEND_NONE;
      if (if_win)                  pend_nxt = PEND_IF;
      else if (d_win && !bus.d_we) pend_nxt = PEND_D;
   end

   always_comb begin
      rvld[0] = (pend == PEND_IF);
      rvld[1] = (pend == PEND_D);
   end

   for (genvar g = 0; g < 2; g++) begin : gen_ret
      mem_rd_return u_ret (
         .CLK     (CLK),
         .RESET   (RESET),
         .rvalid  (rvld[g]),
         .m_rdata (bus.m_rdata),
         .rdata   (rdat[g])
      );
   end

   assign bus.if_rvalid = rvld[0];
   assign bus.d_rvalid  = rvld[1];
   assign bus.if_rdata  = rdat[0];
   assign bus.d_rdata   = rdat[1];

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed bench for otter_mem_arbiter with a synchronous word memory model.
module tb_otter_mem_arbiter;

   logic CLK = 1'b0;
   logic RESET = 1'b1;
   int   n_chk = 0;
   int   n_pass = 0;

   logic [31:0] mem [0:255];

   otter_mem_arbiter_if bus ();

   otter_mem_arbiter #(.MAX_DATA_BURST(3)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   // Memory returns garbage when not reading so held data can be told apart.
   always @(posedge CLK) begin
      if (bus.m_en && bus.m_we)       mem[bus.m_addr[9:2]] <= bus.m_wdata;
      if (bus.m_en && !bus.m_we)      bus.m_rdata <= mem[bus.m_addr[9:2]];
      else                            bus.m_rdata <= $urandom;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, got, exp);
   endtask

   task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                        input logic [31:0] da, input logic [31:0] dwd);
      @(negedge CLK);
      bus.if_req = ir;  bus.if_addr = ia;
      bus.d_req = dr;   bus.d_we = dwe; bus.d_addr = da; bus.d_wdata = dwd;
      bus.d_size = 2'd2; bus.d_sign = 1'b0;
      #1;
   endtask

   initial begin
      logic [2:0] exp_s [0:7];
      exp_s = '{0, 1, 2, 3, 0, 1, 2, 3};
      for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
      mem[5] = 32'h0000_0013;
      bus.m_rdata = '0;

      // reset with both requests asserted
      drive(1, 32'h0, 1, 0, 32'h40, 0);
      chk("rst_if_gnt", bus.if_gnt, 0);
      chk("rst_d_gnt", bus.d_gnt, 0);
      chk("rst_m_en", bus.m_en, 0);
      chk("rst_if_rvalid", bus.if_rvalid, 0);
      chk("rst_if_rdata", bus.if_rdata, 0);
      chk("rst_d_rdata", bus.d_rdata, 0);
      drive(0, 0, 0, 0, 0, 0);
      RESET = 1'b0;

      // fetch only
      drive(1, 32'h0, 0, 0, 0, 0);
      chk("fo_gnt0", bus.if_gnt, 1);
      chk("fo_addr0", bus.m_addr, 32'h0);
      chk("fo_size0", bus.m_size, 2);
      drive(1, 32'h4, 0, 0, 0, 0);
      chk("fo_gnt1", bus.if_gnt, 1);
      chk("fo_rv0", bus.if_rvalid, 1);
      chk("fo_rd0", bus.if_rdata, 32'h1000_0000);
      drive(1, 32'h8, 0, 0, 0, 0);
      chk("fo_rd1", bus.if_rdata, 32'h1000_0001);
      chk("fo_drv", bus.d_rvalid, 0);
      drive(0, 0, 0, 0, 0, 0);
      chk("fo_rv2", bus.if_rvalid, 1);
      chk("fo_rd2", bus.if_rdata, 32'h1000_0002);
      chk("fo_idle_men", bus.m_en, 0);

      // contention: D,D,D,IF repeating
      for (int i = 0; i < 8; i++) begin
         drive(1, 32'h20, 1, 0, 32'h40, 0);
         chk($sformatf("ct_starve%0d", i), 32'(dut.starve_cnt), 32'(exp_s[i]));
         chk($sformatf("ct_if_gnt%0d", i), bus.if_gnt, (i % 4 == 3));
         chk($sformatf("ct_d_gnt%0d", i), bus.d_gnt, (i % 4 != 3));
      end
      drive(0, 0, 0, 0, 0, 0);
      chk("ct_last_rv", bus.if_rvalid, 1);
      chk("ct_last_rd", bus.if_rdata, 32'h1000_0008);

      // store then load
      drive(0, 0, 1, 1, 32'h100, 32'hDEAD_BEEF);
      chk("st_gnt", bus.d_gnt, 1);
      chk("st_we", bus.m_we, 1);
      chk("st_wdata", bus.m_wdata, 32'hDEAD_BEEF);
      drive(0, 0, 1, 0, 32'h100, 0);
      chk("st_no_rv", bus.d_rvalid, 0);
      chk("ld_we", bus.m_we, 0);
      drive(0, 0, 0, 0, 0, 0);
      chk("ld_rv", bus.d_rvalid, 1);
      chk("ld_rd", bus.d_rdata, 32'hDEAD_BEEF);

      // hold
      drive(1, 32'h14, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      chk("hd_rv", bus.if_rvalid, 1);
      chk("hd_rd", bus.if_rdata, 32'h13);
      for (int i = 1; i <= 5; i++) begin
         drive(0, 0, 0, 0, 0, 0);
         chk($sformatf("hd_rv%0d", i), bus.if_rvalid, 0);
         chk($sformatf("hd_rd%0d", i), bus.if_rdata, 32'h13);
      end
      chk("hd_d_rd", bus.d_rdata, 32'hDEAD_BEEF);

      // reset between edges with a fetch outstanding
      drive(1, 32'h8, 0, 0, 0, 0);
      chk("rm_gnt", bus.if_gnt, 1);
      @(posedge CLK);
      #2 RESET = 1'b1;
      #1;
      chk("rm_rv_in_rst", bus.if_rvalid, 0);
      chk("rm_gnt_in_rst", bus.if_gnt, 0);
      chk("rm_men_in_rst", bus.m_en, 0);
      #1 RESET = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      chk("rm_rv", bus.if_rvalid, 0);
      chk("rm_if_hold", bus.if_rdata, 0);
      chk("rm_d_hold", bus.d_rdata, 0);
      chk("rm_starve", 32'(dut.starve_cnt), 0);
      drive(1, 32'h0, 0, 0, 0, 0);
      chk("rm_fo_gnt", bus.if_gnt, 1);
      drive(0, 0, 0, 0, 0, 0);
      chk("rm_fo_rv", bus.if_rvalid, 1);
      chk("rm_fo_rd", bus.if_rdata, 32'h1000_0000);

      // interleave D load, IF, D load
      drive(0, 0, 1, 0, 32'h40, 0);
      drive(1, 32'h44, 0, 0, 0, 0);
      chk("il_drv0", bus.d_rvalid, 1);
      chk("il_drd0", bus.d_rdata, 32'h1000_0010);
      drive(0, 0, 1, 0, 32'h48, 0);
      chk("il_irv", bus.if_rvalid, 1);
      chk("il_ird", bus.if_rdata, 32'h1000_0011);
      chk("il_drv_off", bus.d_rvalid, 0);
      drive(0, 0, 0, 0, 0, 0);
      chk("il_drv1", bus.d_rvalid, 1);
      chk("il_drd1", bus.d_rdata, 32'h1000_0012);
      chk("il_irv_off", bus.if_rvalid, 0);
      chk("il_ird_hold", bus.if_rdata, 32'h1000_0011);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
